rv_io_switch: RTL and testbench

- Sits directly upstream of the CLINT timer and the other IO slaves.
- Accepts single IO transactions from the core-side IO master port and buffers them in a 2-entry request FIFO.
- Decodes each transaction to one slave and drives that slave's addr_req/sel/addr/read/mask/wdata interface.
- For reads, waits for the slave's data_req, captures rdata and returns it to the master. Transactions are strictly in order, with at most one in flight; a timeout counter keeps a dead slave from hanging the bus.

---
 rtl/rv_io_switch.sv | 199 +++++++++++++++++++
 tb/tb_rv_io_switch.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_io_switch.sv
// IO switch between the core-side IO master port and up to 16 IO slaves.
// Buffers requests in a 2-entry FIFO and runs one transaction at a time, with a timeout abort.
module rv_io_switch #(
    parameter int RV      = 64,
    parameter int NDEV    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m_addr_req,
    output logic               m_addr_ack,
    input  logic [19:0]        m_addr,
    input  logic               m_read,
    input  logic [7:0]         m_mask,
    input  logic [RV-1:0]      m_wdata,
    output logic               m_data_req,
    input  logic               m_data_ack,
    output logic [RV-1:0]      m_rdata,
    output logic               addr_req,
    input  logic [NDEV-1:0]    addr_ack,
    output logic [NDEV-1:0]    sel,
    output logic [15:0]        addr,
    output logic               read,
    output logic [7:0]         mask,
    output logic [RV-1:0]      wdata,
    input  logic [NDEV-1:0]    data_req,
    output logic [NDEV-1:0]    data_ack,
    input  logic [NDEV*RV-1:0] rdata,
    output logic               timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;

    localparam logic [4:0]  NDEV_L    = 5'(NDEV);
    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

    logic [19:0]   f_addr  [2];
    logic          f_read  [2];
    logic [7:0]    f_mask  [2];
    logic [RV-1:0] f_wdata [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic          full, empty, push, pop;

    logic [19:0]   h_addr;
    logic          h_read;
    logic [7:0]    h_mask;
    logic [RV-1:0] h_wdata;
    logic [3:0]    h_idx;
    logic          h_mapped;

    state_t        state_q, state_d;
    logic [3:0]    cur_idx_q;
    logic          cur_read_q;
    logic [15:0]   cnt_q;
    logic [RV-1:0] rdata_q;

    logic          ld_cur, cap, clr_rdata, tmo, expired;
    logic          ack_sel, dreq_sel;
    logic [RV-1:0] rd_sel;
    logic [NDEV-1:0] sel_vec;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign push     = m_addr_req && m_addr_ack;
    assign h_addr   = f_addr[rd_ptr];
    assign h_read   = f_read[rd_ptr];
    assign h_mask   = f_mask[rd_ptr];
    assign h_wdata  = f_wdata[rd_ptr];
    assign h_idx    = h_addr[19:16];
    assign h_mapped = ({1'b0, h_idx} < NDEV_L);
    assign expired  = (cnt_q == TIMEOUT_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wr_ptr]  <= m_addr;
            f_read[wr_ptr]  <= m_read;
            f_mask[wr_ptr]  <= m_mask;
            f_wdata[wr_ptr] <= m_wdata;
        end
    end

    // Per-slave selection for the transaction currently owned by the FSM.
    always_comb begin
        ack_sel  = 1'b0;
        dreq_sel = 1'b0;
        rd_sel   = '0;
        sel_vec  = '0;
        for (int k = 0; k < NDEV; k++) begin
            if (cur_idx_q == 4'(k)) begin
                ack_sel    = addr_ack[k];
                dreq_sel   = data_req[k];
                rd_sel     = rdata[k*RV +: RV];
                sel_vec[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        ld_cur    = 1'b0;
        cap       = 1'b0;
        clr_rdata = 1'b0;
        tmo       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (h_mapped) begin
                        ld_cur  = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        pop = 1'b1;
                        if (h_read) begin
                            clr_rdata = 1'b1;
                            state_d   = S_RESP;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (ack_sel) begin
                    pop     = 1'b1;
                    state_d = cur_read_q ? S_WAIT_RD : S_IDLE;
                end else if (expired) begin
                    tmo       = 1'b1;
                    pop       = 1'b1;
                    clr_rdata = cur_read_q;
                    state_d   = cur_read_q ? S_RESP : S_IDLE;
                end
            end
            S_WAIT_RD: begin
                if (dreq_sel) begin
                    cap     = 1'b1;
                    state_d = S_RESP;
                end else if (expired) begin
                    tmo       = 1'b1;
                    clr_rdata = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (m_data_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The stall counter restarts whenever the FSM moves, so each phase gets a full budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_idx_q  <= 4'd0;
            cur_read_q <= 1'b0;
            cnt_q      <= 16'd0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ld_cur) begin
                cur_idx_q  <= h_idx;
                cur_read_q <= h_read;
            end
            if (state_d != state_q)
                cnt_q <= 16'd0;
            else if (state_q == S_ISSUE || state_q == S_WAIT_RD)
                cnt_q <= cnt_q + 16'd1;
            if (cap)
                rdata_q <= rd_sel;
            else if (clr_rdata)
                rdata_q <= '0;
        end
    end

    // Outputs are forced idle while reset is held, whatever the registers still contain.
    assign m_addr_ack = reset || !full;
    assign m_data_req = !reset && (state_q == S_RESP);
    assign m_rdata    = reset ? '0 : rdata_q;
    assign addr_req   = !reset && (state_q == S_ISSUE);
    assign sel        = addr_req ? sel_vec : '0;
    assign addr       = h_addr[15:0];
    assign read       = addr_req && h_read;
    assign mask       = h_mask;
    assign wdata      = h_wdata;
    assign data_ack   = (!reset && state_q == S_WAIT_RD) ? (data_req & sel_vec) : '0;
    assign timeout    = !reset && tmo;

endmodule

// File: tb/tb_rv_io_switch.sv
// Bench for rv_io_switch: slave models plus a scoreboard of expected slave
// transactions and master read responses.
module tb_rv_io_switch;

    localparam int RV = 64;
    localparam int NDEV = 4;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m_addr_req = 1'b0;
    logic              m_addr_ack;
    logic [19:0]       m_addr = '0;
    logic              m_read = 1'b0;
    logic [7:0]        m_mask = '0;
    logic [RV-1:0]     m_wdata = '0;
    logic              m_data_req;
    logic              m_data_ack = 1'b1;
    logic [RV-1:0]     m_rdata;
    logic              addr_req;
    logic [NDEV-1:0]   addr_ack;
    logic [NDEV-1:0]   sel;
    logic [15:0]       addr;
    logic              read;
    logic [7:0]        mask;
    logic [RV-1:0]     wdata;
    logic [NDEV-1:0]   data_req;
    logic [NDEV-1:0]   data_ack;
    logic [NDEV*RV-1:0] rdata;
    logic              timeout;

    logic [NDEV-1:0]   ack_en = '1;
    logic [NDEV-1:0]   resp_en = 4'b1011;
    logic [NDEV-1:0]   pending = '0;
    logic [RV-1:0]     mem [NDEV] = '{default: '0};

    typedef struct {
        logic [3:0]    idx;
        logic [15:0]   addr;
        logic          rd;
        logic [7:0]    mask;
        logic [RV-1:0] wdata;
    } iss_t;

    iss_t          exp_iss[$];
    logic [RV-1:0] exp_resp[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    rv_io_switch #(.RV(RV), .NDEV(NDEV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m_addr_req(m_addr_req), .m_addr_ack(m_addr_ack), .m_addr(m_addr),
        .m_read(m_read), .m_mask(m_mask), .m_wdata(m_wdata),
        .m_data_req(m_data_req), .m_data_ack(m_data_ack), .m_rdata(m_rdata),
        .addr_req(addr_req), .addr_ack(addr_ack), .sel(sel), .addr(addr),
        .read(read), .mask(mask), .wdata(wdata),
        .data_req(data_req), .data_ack(data_ack), .rdata(rdata),
        .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave models: simple byte-masked register per slave; read data one cycle after accept.
    assign addr_ack = ack_en & sel & {NDEV{addr_req}};
    assign data_req = pending & resp_en;
    always_comb begin
        for (int k = 0; k < NDEV; k++) rdata[k*RV +: RV] = mem[k];
    end
    always @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int k = 0; k < NDEV; k++) begin
                if (addr_ack[k]) begin
                    if (read) begin
                        pending[k] <= 1'b1;
                    end else begin
                        for (int b = 0; b < 8; b++)
                            if (mask[b]) mem[k][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
                if (data_req[k] && data_ack[k]) pending[k] <= 1'b0;
            end
        end
    end

    task automatic monitor();
        iss_t e;
        logic [NDEV-1:0] es;
        logic [RV-1:0] er;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (addr_req && (|(addr_ack & sel))) begin
                    n_checks++;
                    if (exp_iss.size() == 0) begin
                        n_fail++;
                        $display("FAIL iss_unexpected: sel=%b addr=%h read=%b, required no transaction", sel, addr, read);
                    end else begin
                        e = exp_iss.pop_front();
                        es = 4'b0001 << e.idx;
                        if ({sel, addr, read, mask, wdata} !== {es, e.addr, e.rd, e.mask, e.wdata}) begin
                            n_fail++;
                            $display("FAIL iss_fields: got sel=%b addr=%h rd=%b mask=%h wdata=%h, required sel=%b addr=%h rd=%b mask=%h wdata=%h",
                                     sel, addr, read, mask, wdata, es, e.addr, e.rd, e.mask, e.wdata);
                        end
                    end
                end
                if (m_data_req && m_data_ack) begin
                    n_checks++;
                    if (exp_resp.size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected: m_rdata=%h, required no response", m_rdata);
                    end else begin
                        er = exp_resp.pop_front();
                        if (m_rdata !== er) begin
                            n_fail++;
                            $display("FAIL resp_data: got %h required %h", m_rdata, er);
                        end
                    end
                end
            end
        end
    endtask

    task automatic push_req(input logic [19:0] a, input logic rd, input logic [7:0] mk,
                            input logic [RV-1:0] wd, input logic [RV-1:0] expd, output int acc);
        @(posedge clk); #1;
        m_addr_req = 1'b1; m_addr = a; m_read = rd; m_mask = mk; m_wdata = wd;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_addr_ack) begin
                acc = cyc;
                if (int'(a[19:16]) < NDEV) exp_iss.push_back('{a[19:16], a[15:0], rd, mk, wd});
                if (rd) exp_resp.push_back(expd);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        m_addr_req = 1'b0;
        n_checks++;
        if (acc < 0) begin
            n_fail++;
            $display("FAIL push_accept: request %h never accepted, required acceptance", a);
        end
    endtask

    task automatic wait_idle(input string name);
        logic done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_iss.size() == 0 && exp_resp.size() == 0 && !m_data_req && !addr_req) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: iss pending=%0d resp pending=%0d, required 0/0", name, exp_iss.size(), exp_resp.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({m_addr_ack, m_data_req, m_rdata, addr_req, sel, data_ack, timeout} !== {1'b1, 1'b0, 64'h0, 1'b0, 4'h0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_during: ack=%b dreq=%b rdata=%h areq=%b sel=%b dack=%b tmo=%b, required 1 0 0 0 0000 0000 0",
                     m_addr_ack, m_data_req, m_rdata, addr_req, sel, data_ack, timeout);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m_addr_ack, m_data_req, m_rdata, addr_req, sel, data_ack, timeout} !== {1'b1, 1'b0, 64'h0, 1'b0, 4'h0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_after: ack=%b dreq=%b rdata=%h areq=%b sel=%b dack=%b tmo=%b, required 1 0 0 0 0000 0000 0",
                     m_addr_ack, m_data_req, m_rdata, addr_req, sel, data_ack, timeout);
        end
    endtask

    task automatic test_write();
        int acc, seen;
        m_data_ack = 1'b1;
        push_req(20'h04008, 1'b0, 8'hFF, 64'h1234, 64'h0, acc);
        seen = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (addr_req) begin seen = cyc; break; end
        end
        n_checks++;
        if (seen != acc + 2 || sel !== 4'b0001 || addr !== 16'h4008) begin
            n_fail++;
            $display("FAIL wr_issue: addr_req at +%0d sel=%b addr=%h, required +2 sel=0001 addr=4008", seen - acc, sel, addr);
        end
        wait_idle("write");
    endtask

    task automatic test_read_timer();
        int acc, seen;
        m_data_ack = 1'b0;
        push_req(20'h04008, 1'b1, 8'h00, 64'h0, 64'h1234, acc);
        seen = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_data_req) begin seen = cyc; break; end
        end
        n_checks++;
        if (seen != acc + 4 || m_rdata !== 64'h1234) begin
            n_fail++;
            $display("FAIL rd_latency: m_data_req at +%0d rdata=%h, required +4 rdata=1234", seen - acc, m_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_data_req !== 1'b1 || m_rdata !== 64'h1234) begin
                n_fail++;
                $display("FAIL rd_hold: dreq=%b rdata=%h, required 1 1234", m_data_req, m_rdata);
            end
        end
        @(posedge clk); #1 m_data_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (m_data_req !== 1'b0 || m_rdata !== 64'h1234) begin
            n_fail++;
            $display("FAIL rd_release: dreq=%b rdata=%h, required 0 1234", m_data_req, m_rdata);
        end
        wait_idle("read");
    endtask

    task automatic test_unmapped();
        int acc;
        logic bad = 1'b0;
        push_req(20'hF0000, 1'b1, 8'h00, 64'h0, 64'h0, acc);
        push_req(20'hF1234, 1'b0, 8'hFF, 64'h55, 64'h0, acc);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (addr_req || timeout) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL unmapped_quiet: addr_req or timeout seen=1, required 0");
        end
        wait_idle("unmapped");
    endtask

    task automatic test_timeout();
        int acc, a_cyc, t_cyc;
        push_req(20'h20010, 1'b1, 8'h00, 64'h0, 64'h0, acc);
        a_cyc = -1; t_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (addr_req && addr_ack[2]) begin a_cyc = cyc; break; end
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (timeout) begin t_cyc = cyc; break; end
        end
        n_checks++;
        if (a_cyc < 0 || t_cyc != a_cyc + 1 + TIMEOUT) begin
            n_fail++;
            $display("FAIL tmo_time: timeout %0d cycles after WAIT_RD entry, required %0d", t_cyc - a_cyc - 1, TIMEOUT);
        end
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b0 || m_data_req !== 1'b1 || m_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL tmo_after: tmo=%b dreq=%b rdata=%h, required 0 1 0", timeout, m_data_req, m_rdata);
        end
        wait_idle("timeout");
    endtask

    task automatic test_back_to_back();
        logic [19:0]   ba [3];
        logic [7:0]    bm [3];
        logic [RV-1:0] bw [3];
        int acc [3];
        int pop_c = -1;
        int n = 0;
        ba[0] = 20'h00010; bm[0] = 8'hFF; bw[0] = 64'hA1;
        ba[1] = 20'h00018; bm[1] = 8'hFF; bw[1] = 64'hA2;
        ba[2] = 20'h00020; bm[2] = 8'h01; bw[2] = 64'hFFFF_FFFF_FFFF_FFB3;
        acc[0] = -100; acc[1] = -100; acc[2] = -100;
        ack_en[0] = 1'b0;
        @(posedge clk); #1;
        m_addr_req = 1'b1; m_addr = ba[0]; m_read = 1'b0; m_mask = bm[0]; m_wdata = bw[0];
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clk);
            if (pop_c < 0 && addr_req && addr_ack[0]) pop_c = cyc;
            if (n == 2 && cyc == acc[1] + 1) begin
                n_checks++;
                if (m_addr_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_full: m_addr_ack=%b with two queued, required 0", m_addr_ack);
                end
            end
            if (m_addr_req && m_addr_ack) begin
                acc[n] = cyc;
                exp_iss.push_back('{4'd0, ba[n][15:0], 1'b0, bm[n], bw[n]});
                n++;
            end
            @(posedge clk); #1;
            if (n > 0 && cyc == acc[0] + 4) ack_en[0] = 1'b1;
            if (n < 3) begin
                m_addr = ba[n]; m_mask = bm[n]; m_wdata = bw[n];
            end else begin
                m_addr_req = 1'b0;
            end
        end
        m_addr_req = 1'b0;
        ack_en[0] = 1'b1;
        n_checks++;
        if (n != 3 || pop_c != acc[0] + 4 || acc[2] != pop_c + 1) begin
            n_fail++;
            $display("FAIL b2b_third: accepted=%0d third at %0d first pop at %0d, required 3 accepted, third one cycle after pop",
                     n, acc[2], pop_c);
        end
        wait_idle("b2b");
    endtask

    task automatic test_reset_mid();
        int acc, a_cyc;
        logic bad = 1'b0;
        push_req(20'h20020, 1'b1, 8'h00, 64'h0, 64'h0, acc);
        a_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (addr_req && addr_ack[2]) begin a_cyc = cyc; break; end
        end
        @(posedge clk); #1;
        m_addr_req = 1'b1; m_addr = 20'h00000; m_read = 1'b0; m_mask = 8'hFF; m_wdata = 64'hDEAD;
        @(negedge clk);
        @(posedge clk); #1;
        m_addr_req = 1'b0;
        reset = 1'b1;
        exp_iss.delete();
        exp_resp.delete();
        @(negedge clk);
        n_checks++;
        if (a_cyc < 0 || m_data_req !== 1'b0 || addr_req !== 1'b0 || m_addr_ack !== 1'b1 || data_ack !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_mid_during: dreq=%b areq=%b ack=%b dack=%b, required 0 0 1 0000", m_data_req, addr_req, m_addr_ack, data_ack);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_data_req !== 1'b0 || m_addr_ack !== 1'b1 || m_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_mid_after: dreq=%b ack=%b rdata=%h, required 0 1 0", m_data_req, m_addr_ack, m_rdata);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (addr_req || m_data_req) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_mid_flush: stale request issued after reset=1, required 0");
        end
        push_req(20'h00008, 1'b1, 8'h00, 64'h0, 64'hB3, acc);
        wait_idle("post_reset");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_write();
        test_read_timer();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
